// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between two requesters.
//   Port 0 is the CPU (fetch/load/store); port 1 is a debug loader/DMA master.
//   Each port uses a req/ack handshake. The winner's we/addr/wdata are latched
//   at grant and held on mem_* for LAT cycles. The ack is one cycle long.
// Build option:
//   MEMARB_RR_EN defined   -> round-robin tie-break (last_grant tracks the previous winner).
//   MEMARB_RR_EN undefined -> fixed priority, port 0 wins every tie.
module mem_port_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned   CW      = $clog2(LAT + 1);
    localparam logic [CW-1:0] CntLoad = CW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sel;    // port that owns the transaction in flight
    logic          pick1;  // port 1 wins the arbitration this cycle

`ifdef MEMARB_RR_EN
    logic last_grant;

    // Round-robin: a tie goes to the port that did not win last time
    always_comb pick1 = req1 & (~req0 | ~last_grant);
`else
    // Fixed priority: port 1 only wins while port 0 is not requesting
    always_comb pick1 = req1 & ~req0;
`endif

    assign busy = (state != StIdle);

    // Transaction FSM: grant in IDLE, hold the strobes for LAT cycles, then pulse ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= '0;
            sel       <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEMARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                StIdle: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        sel       <= pick1;
                        mem_en    <= 1'b1;
                        mem_we    <= pick1 ? we1 : we0;
                        mem_addr  <= pick1 ? addr1 : addr0;
                        mem_wdata <= pick1 ? wdata1 : wdata0;
                        cnt       <= CntLoad;
                        state     <= StAccess;
`ifdef MEMARB_RR_EN
                        last_grant <= pick1;
`endif
                    end
                end
                StAccess: begin
                    if (cnt == '0) begin
                        // mem_rdata is valid in this last access cycle; writes return 0
                        if (sel) begin
                            ack1   <= 1'b1;
                            rdata1 <= mem_we ? '0 : mem_rdata;
                        end else begin
                            ack0   <= 1'b1;
                            rdata0 <= mem_we ? '0 : mem_rdata;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDone: begin
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    rdata0 <= '0;
                    rdata1 <= '0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a cycle-schedule model (grant at edge g -> strobes after edges g..g+LAT-1,
// ack after edge g+LAT, next arbitration at edge g+LAT+2).
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int tests;
    int fails;
    int unsigned en_cnt;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req[0]),
        .we0       (we[0]),
        .addr0     (addr[0]),
        .wdata0    (wdata[0]),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .req1      (req[1]),
        .we1       (we[1]),
        .addr1     (addr[1]),
        .wdata1    (wdata[1]),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the address
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Memory model: data valid only in the LAT-th cycle of an access, garbage otherwise
    always @(posedge clk or negedge rst) begin
        if (!rst) en_cnt <= 0;
        else      en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
    always_comb begin
        mem_rdata = 32'hBAD0_0000 | en_cnt;
        if (mem_en && en_cnt == LAT - 1) mem_rdata = mem_val(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req      = 2'b00;
        we       = 2'b00;
        addr[0]  = '0;
        addr[1]  = '0;
        wdata[0] = '0;
        wdata[1] = '0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 2'b11;
        we  = 2'b11;
        addr[0] = 32'h44; addr[1] = 32'h88;
        wdata[0] = 32'h1; wdata[1] = 32'h2;
        repeat (3) step();
        tests++;
        if ({ack0, ack1, mem_en, mem_we, busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl got=%b exp=00000", {ack0, ack1, mem_en, mem_we, busy});
        end
        tests++;
        if ({rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", rdata0, rdata1, mem_addr, mem_wdata);
        end
        apply_reset();
        step();
        tests++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got busy=%b en=%b exp 0 0", busy, mem_en);
        end
    endtask

    task automatic test_read();
        apply_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'h0;
        step();
        for (int k = 0; k < LAT; k++) begin
            tests++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || ack0 !== 1'b0) begin
                fails++;
                $display("FAIL read_access k=%0d got en=%b addr=%h we=%b ack0=%b exp 1 10 0 0",
                         k, mem_en, mem_addr, mem_we, ack0);
            end
            step();
        end
        tests++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL read_ack got ack0=%b rdata0=%h exp 1 deadbeef", ack0, rdata0);
        end
        tests++;
        if (ack1 !== 1'b0 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL read_other got ack1=%b en=%b exp 0 0", ack1, mem_en);
        end
        req[0] = 1'b0;
        step();
        tests++;
        if (ack0 !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_after got ack0=%b busy=%b exp 0 0", ack0, busy);
        end
    endtask

    task automatic test_write();
        apply_reset();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h1234_5678;
        step();
        for (int k = 0; k < LAT; k++) begin
            tests++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
                mem_wdata !== 32'h1234_5678) begin
                fails++;
                $display("FAIL write_access k=%0d got en=%b we=%b addr=%h wd=%h exp 1 1 40 12345678",
                         k, mem_en, mem_we, mem_addr, mem_wdata);
            end
            step();
        end
        tests++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL write_ack got ack1=%b ack0=%b rdata1=%h exp 1 0 0", ack1, ack0, rdata1);
        end
        req[1] = 1'b0;
    endtask

    task automatic test_tie();
        int got;
        int exp_port;
        apply_reset();
        req = 2'b11; we = 2'b00; addr[0] = 32'h100; addr[1] = 32'h200;
        for (int t = 0; t < 4; t++) begin
            got = -1;
            for (int c = 0; c < LAT + 4; c++) begin
                step();
                if (ack0 || ack1) begin
                    got = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                    break;
                end
            end
`ifdef MEMARB_RR_EN
            exp_port = t % 2;
`else
            exp_port = 0;
`endif
            tests++;
            if (got != exp_port) begin
                fails++;
                $display("FAIL tie_grant t=%0d got port=%0d exp port=%0d", t, got, exp_port);
            end
            tests++;
            if ((got == 0 && rdata0 !== mem_val(32'h100)) ||
                (got == 1 && rdata1 !== mem_val(32'h200))) begin
                fails++;
                $display("FAIL tie_rdata t=%0d got %h/%h", t, rdata0, rdata1);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_withdraw();
        int extra;
        apply_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h80; wdata[0] = 32'h55;
        step();
        addr[0] = 32'h84; we[0] = 1'b1; wdata[0] = 32'hFFFF; req[0] = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tests++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0 ||
                mem_wdata !== 32'h55) begin
                fails++;
                $display("FAIL withdraw_access k=%0d got en=%b addr=%h we=%b wd=%h exp 1 80 0 55",
                         k, mem_en, mem_addr, mem_we, mem_wdata);
            end
            step();
        end
        tests++;
        if (ack0 !== 1'b1 || rdata0 !== mem_val(32'h80)) begin
            fails++;
            $display("FAIL withdraw_ack got ack0=%b rdata0=%h exp 1 %h", ack0, rdata0,
                     mem_val(32'h80));
        end
        extra = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            step();
            if (ack0 || ack1 || mem_en) extra++;
        end
        tests++;
        if (extra != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_after got extra=%0d busy=%b exp 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFE;
        step();
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({mem_en, mem_we, busy, ack0, ack1} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            fails++;
            $display("FAIL rstmid_async got en=%b we=%b busy=%b addr=%h wd=%h exp all 0",
                     mem_en, mem_we, busy, mem_addr, mem_wdata);
        end
        we[0] = 1'b0; addr[0] = 32'h30;
        seen = 0;
        repeat (LAT + 2) begin
            step();
            if (ack0 || ack1 || mem_en) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rstmid_noack got activity=%0d exp 0", seen);
        end
        #2 rst = 1'b1;
        step();
        for (int k = 0; k < LAT; k++) begin
            tests++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h30 || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_access k=%0d got en=%b addr=%h we=%b exp 1 30 0",
                         k, mem_en, mem_addr, mem_we);
            end
            step();
        end
        tests++;
        if (ack0 !== 1'b1 || rdata0 !== mem_val(32'h30)) begin
            fails++;
            $display("FAIL rstmid_ack got ack0=%b rdata0=%h exp 1 %h", ack0, rdata0,
                     mem_val(32'h30));
        end
        req[0] = 1'b0;
    endtask

    task automatic test_random(input int n);
        bit            active;
        int            g, e, d, port, lg;
        logic          t_we;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_wdata;
        logic [4:0]    exp_ctl, got_ctl;
        logic [DW-1:0] exp_rd;
        bit            exp_en, exp_ack, inflight;
        apply_reset();
        active = 0; g = 0; e = 0; lg = 1; port = 0;
        t_we = 0; t_addr = '0; t_wdata = '0;
        for (int i = 0; i < n; i++) begin
            // Arbitration at edge e, only when the port is free
            if ((!active || e >= g + int'(LAT) + 2) && req != 2'b00) begin
`ifdef MEMARB_RR_EN
                if (req == 2'b11) port = (lg == 1) ? 0 : 1;
                else              port = req[1] ? 1 : 0;
                lg = port;
`else
                port = req[0] ? 0 : 1;
`endif
                t_we = we[port]; t_addr = addr[port]; t_wdata = wdata[port];
                g = e; active = 1;
            end
            step();
            d       = e - g;
            exp_en  = active && d < int'(LAT);
            exp_ack = active && d == int'(LAT);
            exp_ctl = {exp_en, exp_en & t_we, active && d <= int'(LAT),
                       exp_ack && port == 0, exp_ack && port == 1};
            got_ctl = {mem_en, mem_we, busy, ack0, ack1};
            tests++;
            if (got_ctl !== exp_ctl) begin
                fails++;
                $display("FAIL rnd_ctl edge=%0d got en,we,busy,ack0,ack1=%b exp %b",
                         e, got_ctl, exp_ctl);
            end
            tests++;
            if (mem_addr !== (exp_en ? t_addr : '0) || mem_wdata !== (exp_en ? t_wdata : '0)) begin
                fails++;
                $display("FAIL rnd_bus edge=%0d got addr=%h wd=%h exp %h %h", e, mem_addr,
                         mem_wdata, exp_en ? t_addr : '0, exp_en ? t_wdata : '0);
            end
            if (exp_ack) begin
                exp_rd = t_we ? '0 : mem_val(t_addr);
                tests++;
                if ((port == 0 ? rdata0 : rdata1) !== exp_rd) begin
                    fails++;
                    $display("FAIL rnd_rdata edge=%0d port=%0d got %h exp %h", e, port,
                             port == 0 ? rdata0 : rdata1, exp_rd);
                end
            end
            // Requester behaviour for the next edge
            for (int x = 0; x < 2; x++) begin
                inflight = active && port == x && d <= int'(LAT);
                if (active && port == x && d == int'(LAT) + 1) begin
                    req[x] = 1'b0;
                end else if (active && port == x && d < int'(LAT)) begin
                    if ($urandom_range(3) == 0) begin
                        we[x] = 1'($urandom); addr[x] = $urandom; wdata[x] = $urandom;
                    end
                    if ($urandom_range(5) == 0) req[x] = 1'b0;
                end else if (!req[x] && !inflight && $urandom_range(2) == 0) begin
                    req[x] = 1'b1; we[x] = 1'($urandom); addr[x] = $urandom; wdata[x] = $urandom;
                end
            end
            e++;
        end
        req = 2'b00;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_withdraw();
        test_reset_mid();
        test_random(2000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "simulation time limit reached");
    end

endmodule
